// File: rtl/aes_round_ctrl_if.sv
// Control/status bundle between the AES round sequencer and its datapath.
interface aes_round_ctrl_if;
   logic       start;
   logic       busy;
   logic       done;
   logic [3:0] round;
   logic [1:0] sel;
   logic       ld_state;
   logic       ld_key;
   logic       key_step;
   logic [7:0] rcon;

   modport master (
      output start,
      input  busy, done, round, sel, ld_state, ld_key, key_step, rcon
   );

   modport slave (
      input  start,
      output busy, done, round, sel, ld_state, ld_key, key_step, rcon
   );
endinterface

// File: rtl/aes_round_ctrl.sv
// AES round sequencer: INIT, NROUNDS-1 full rounds, FINAL, DONE; all outputs registered.
// Optional macro AES_RCON_GEN_EN drives the AES round constant on rcon; otherwise rcon is 8'h00.
module aes_round_ctrl #(
   parameter int NROUNDS = 10
) (
   input  logic            clk,
   input  logic            rst,
   aes_round_ctrl_if.slave bus
);
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_INIT  = 3'd1,
      ST_ROUND = 3'd2,
      ST_FINAL = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   localparam logic [3:0] LAST_ROUND = 4'(NROUNDS);
   localparam logic [3:0] PEN_ROUND  = 4'(NROUNDS - 1);

   state_t     state_r, state_next_s;
   logic [3:0] round_r, round_next_s;
   logic       busy_r, busy_next_s;
   logic       done_r, done_next_s;
   logic [1:0] sel_r, sel_next_s;
   logic       ld_state_r, ld_state_next_s;
   logic       ld_key_r, ld_key_next_s;
   logic       key_step_r, key_step_next_s;

   // Next FSM state and round index.
   always_comb begin
      state_next_s = state_r;
      round_next_s = round_r;
      case (state_r)
         ST_IDLE: begin
            round_next_s = 4'd0;
            if (bus.start) state_next_s = ST_INIT;
            else           state_next_s = ST_IDLE;
         end
         ST_INIT: begin
            state_next_s = ST_ROUND;
            round_next_s = 4'd1;
         end
         ST_ROUND: begin
            round_next_s = round_r + 4'd1;
            if (round_r >= PEN_ROUND) state_next_s = ST_FINAL;
            else                      state_next_s = ST_ROUND;
         end
         ST_FINAL: begin
            state_next_s = ST_DONE;
            round_next_s = LAST_ROUND;
         end
         ST_DONE: begin
            state_next_s = ST_IDLE;
            round_next_s = 4'd0;
         end
         default: begin
            state_next_s = ST_IDLE;
            round_next_s = 4'd0;
         end
      endcase
   end

   // Output decode of the upcoming state so the strobes come straight from flops.
   always_comb begin
      busy_next_s     = 1'b0;
      done_next_s     = 1'b0;
      sel_next_s      = 2'd3;
      ld_state_next_s = 1'b0;
      ld_key_next_s   = 1'b0;
      key_step_next_s = 1'b0;
      case (state_next_s)
         ST_IDLE: sel_next_s = 2'd3;
         ST_INIT: begin
            busy_next_s     = 1'b1;
            sel_next_s      = 2'd0;
            ld_state_next_s = 1'b1;
            ld_key_next_s   = 1'b1;
         end
         ST_ROUND: begin
            busy_next_s     = 1'b1;
            sel_next_s      = 2'd1;
            ld_state_next_s = 1'b1;
            key_step_next_s = 1'b1;
         end
         ST_FINAL: begin
            busy_next_s     = 1'b1;
            sel_next_s      = 2'd2;
            ld_state_next_s = 1'b1;
            key_step_next_s = 1'b1;
         end
         ST_DONE: done_next_s = 1'b1;
         default: sel_next_s = 2'd3;
      endcase
   end

   // State, round counter and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         round_r    <= 4'd0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         sel_r      <= 2'd3;
         ld_state_r <= 1'b0;
         ld_key_r   <= 1'b0;
         key_step_r <= 1'b0;
      end else begin
         state_r    <= state_next_s;
         round_r    <= round_next_s;
         busy_r     <= busy_next_s;
         done_r     <= done_next_s;
         sel_r      <= sel_next_s;
         ld_state_r <= ld_state_next_s;
         ld_key_r   <= ld_key_next_s;
         key_step_r <= key_step_next_s;
      end
   end

   assign bus.busy     = busy_r;
   assign bus.done     = done_r;
   assign bus.round    = round_r;
   assign bus.sel      = sel_r;
   assign bus.ld_state = ld_state_r;
   assign bus.ld_key   = ld_key_r;
   assign bus.key_step = key_step_r;

`ifdef AES_RCON_GEN_EN
   logic [7:0] rcon_r, rcon_next_s;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
   endfunction

   // Round constant: seeded to 01 on entry to round 1, then doubled in GF(2^8).
   always_comb begin
      rcon_next_s = 8'h00;
      if (state_next_s == ST_ROUND || state_next_s == ST_FINAL) begin
         if (state_r == ST_INIT) rcon_next_s = 8'h01;
         else                    rcon_next_s = xtime(rcon_r);
      end else begin
         rcon_next_s = 8'h00;
      end
   end

   // Round constant register.
   always_ff @(posedge clk) begin
      if (rst) rcon_r <= 8'h00;
      else     rcon_r <= rcon_next_s;
   end

   assign bus.rcon = rcon_r;
`else
   assign bus.rcon = 8'h00;
`endif
endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: NROUNDS=10 and NROUNDS=2 instances against a position-in-operation model.
module tb_aes_round_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   aes_round_ctrl_if bus10 ();
   aes_round_ctrl_if bus2 ();

   aes_round_ctrl #(.NROUNDS(10)) dut10 (.clk(clk), .rst(rst), .bus(bus10));
   aes_round_ctrl #(.NROUNDS(2))  dut2  (.clk(clk), .rst(rst), .bus(bus2));

   int nvec = 0;
   int nmis = 0;

   // Model: k = 0 idle, otherwise the 1-based cycle within an operation (1 = INIT, nr+2 = DONE).
   int k10 = 0;
   int k2  = 0;

   logic [7:0] rcon_tbl [0:15] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                                   8'h80, 8'h1B, 8'h36, 8'h6C, 8'hD8, 8'hAB, 8'h4D, 8'h9A};

   function automatic int next_k(input int k, input int nr, input logic s, input logic r);
      if (r)              return 0;
      else if (k == 0)    return s ? 1 : 0;
      else if (k == nr+2) return 0;
      else                return k + 1;
   endfunction

   always @(posedge clk) begin
      k10 <= next_k(k10, 10, bus10.start, rst);
      k2  <= next_k(k2, 2, bus2.start, rst);
   end

   function automatic logic [7:0] rcon_of(input int r);
`ifdef AES_RCON_GEN_EN
      return rcon_tbl[r];
`else
      return 8'h00;
`endif
   endfunction

   // Expected {busy,done,round,sel,ld_state,ld_key,key_step,rcon}.
   function automatic logic [18:0] exp_out(input int nr, input int k);
      logic b, d, lds, ldk, ks;
      logic [3:0] rnd;
      logic [1:0] sl;
      logic [7:0] rc;
      b = 1'b0; d = 1'b0; lds = 1'b0; ldk = 1'b0; ks = 1'b0;
      rnd = 4'd0; sl = 2'd3; rc = 8'h00;
      if (k == 1) begin
         b = 1'b1; sl = 2'd0; lds = 1'b1; ldk = 1'b1;
      end else if (k >= 2 && k <= nr) begin
         b = 1'b1; rnd = 4'(k-1); sl = 2'd1; lds = 1'b1; ks = 1'b1; rc = rcon_of(k-1);
      end else if (k == nr+1) begin
         b = 1'b1; rnd = 4'(nr); sl = 2'd2; lds = 1'b1; ks = 1'b1; rc = rcon_of(nr);
      end else if (k == nr+2) begin
         d = 1'b1; rnd = 4'(nr);
      end
      return {b, d, rnd, sl, lds, ldk, ks, rc};
   endfunction

   function automatic logic [18:0] act10();
      return {bus10.busy, bus10.done, bus10.round, bus10.sel, bus10.ld_state,
              bus10.ld_key, bus10.key_step, bus10.rcon};
   endfunction

   function automatic logic [18:0] act2();
      return {bus2.busy, bus2.done, bus2.round, bus2.sel, bus2.ld_state,
              bus2.ld_key, bus2.key_step, bus2.rcon};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic compare_cycle();
      chk("outs10", 32'(act10()), 32'(exp_out(10, k10)));
      chk("outs2", 32'(act2()), 32'(exp_out(2, k2)));
      chk("sel_vs_ld10", 32'(bus10.sel != 2'd3), 32'(bus10.ld_state));
      chk("sel_vs_ld2", 32'(bus2.sel != 2'd3), 32'(bus2.ld_state));
      chk("key_overlap10", 32'(bus10.ld_key & bus10.key_step), 32'd0);
      chk("key_overlap2", 32'(bus2.ld_key & bus2.key_step), 32'd0);
   endtask

   // One clock: drive inputs, let the edge pass, then check every output against the model.
   task automatic tick(input logic s, input logic r);
      bus10.start = s;
      bus2.start  = s;
      rst         = r;
      @(posedge clk);
      #1;
      compare_cycle();
   endtask

   task automatic run_latency(output int l10, output int l2);
      l10 = 0;
      l2  = 0;
      for (int i = 1; i <= 30; i++) begin
         tick((i == 1) ? 1'b1 : 1'b0, 1'b0);
         if (i == 11) begin
            chk("final_round10", 32'(bus10.round), 32'd10);
            chk("final_sel10", 32'(bus10.sel), 32'd2);
`ifdef AES_RCON_GEN_EN
            chk("final_rcon10", 32'(bus10.rcon), 32'h36);
`else
            chk("final_rcon10", 32'(bus10.rcon), 32'h00);
`endif
         end
         if (bus10.done && l10 == 0) l10 = i;
         if (bus2.done && l2 == 0) l2 = i;
         if (l10 != 0 && l2 != 0) break;
      end
   endtask

   initial begin
      int lat10, lat2, ndone;
      int dq[$];
      bus10.start = 1'b0;
      bus2.start  = 1'b0;

      // Reset, with start asserted to show reset priority.
      tick(1'b1, 1'b1);
      tick(1'b0, 1'b1);
      chk("reset_idle10", 32'(act10()), 32'h01800);
      chk("reset_idle2", 32'(act2()), 32'h01800);

      // Single operation, start honoured in the first cycle after reset.
      run_latency(lat10, lat2);
      chk("latency10", 32'(lat10), 32'd12);
      chk("latency2", 32'(lat2), 32'd4);
      tick(1'b0, 1'b0);

      // Starts during INIT, round 5 and DONE are ignored.
      ndone = 0;
      for (int e = 1; e <= 35; e++) begin
         tick((e == 1 || e == 2 || e == 7 || e == 13) ? 1'b1 : 1'b0, 1'b0);
         if (e == 6) chk("round5", 32'(bus10.round), 32'd5);
         if (bus10.done) ndone++;
      end
      chk("single_done", 32'(ndone), 32'd1);

      // Reset during round 6, then a clean operation.
      tick(1'b1, 1'b0);
      for (int e = 2; e <= 7; e++) tick(1'b0, 1'b0);
      chk("round6", 32'(bus10.round), 32'd6);
      tick(1'b1, 1'b1);
      chk("mid_reset10", 32'(act10()), 32'h01800);
      run_latency(lat10, lat2);
      chk("latency_after_rst", 32'(lat10), 32'd12);
      tick(1'b0, 1'b0);

      // start held high for 40 cycles.
      for (int i = 1; i <= 40; i++) begin
         tick(1'b1, 1'b0);
         if (bus10.done) dq.push_back(i);
      end
      chk("b2b_count", 32'(dq.size()), 32'd3);
      for (int j = 0; j < 3; j++)
         chk("b2b_done_cycle", (dq.size() > j) ? 32'(dq[j]) : 32'd0, 32'(12 + 13*j));

      // Random start / occasional reset.
      for (int i = 0; i < 500; i++)
         tick(($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
              ($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end
endmodule
